mips_muldiv: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/mips_muldiv_step.sv | 31 +++
 rtl/mips_muldiv.sv | 135 +++++++++++++
 tb/tb_mips_muldiv.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: decode opcode/funct fields and the mul/div unit's op and state types.
package mips_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_t;

    typedef enum logic [5:0] {
        OPC_SPECIAL = 6'h00,
        OPC_BEQ     = 6'h04,
        OPC_ADDIU   = 6'h09,
        OPC_LW      = 6'h23,
        OPC_SW      = 6'h2b
    } opcode_t;

    typedef enum logic [5:0] {
        FN_MFHI  = 6'h10,
        FN_MTHI  = 6'h11,
        FN_MFLO  = 6'h12,
        FN_MTLO  = 6'h13,
        FN_MULT  = 6'h18,
        FN_MULTU = 6'h19,
        FN_DIV   = 6'h1a,
        FN_DIVU  = 6'h1b,
        FN_ADDU  = 6'h21
    } funct_t;

endpackage

// File: rtl/mips_muldiv_step.sv
// One radix-2 step. Multiply: acc = {partial, multiplier}, add-then-shift-right.
// Divide: acc = {remainder, dividend/quotient}, restoring shift-subtract.
module mips_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff   = rem_sh - {1'b0, operand};
        if (is_div) begin
            // Borrow out means remainder < divisor: keep it, quotient bit 0.
            if (diff[WIDTH])
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO; UNROLL radix-2 steps per cycle.
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int ITER = WIDTH / UNROLL;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    muldiv_state_t state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic                 is_div, sgn_a, sgn_b, div_zero;
    logic [UNROLL:0][2*WIDTH-1:0] chain;

    logic                 accept, is_arith, op_signed, op_div;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign accept    = start && !busy && !cancel;
    assign is_arith  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    // Magnitudes are unsigned WIDTH-bit, so |MIN| = 2^(WIDTH-1) stays exact.
    assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

    assign chain[0] = acc;
    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
            .is_div   (is_div),
            .acc      (chain[g]),
            .operand  (opnd),
            .acc_next (chain[g+1])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cancel) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept && is_arith) state_nxt = ST_RUN;
                ST_RUN:  if (cnt == LAST)        state_nxt = ST_FIX;
                ST_FIX:                          state_nxt = ST_IDLE;
                default:                         state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != ST_IDLE);
    end

    // Sign correction applied on the FIX edge; remainder follows the dividend's sign.
    always_comb begin
        prod_fix = (sgn_a ^ sgn_b) ? -acc : acc;
        quo_fix  = div_zero ? '1 : ((sgn_a ^ sgn_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem_fix  = sgn_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            sgn_a    <= 1'b0;
            sgn_b    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (accept) begin
                        if (op == OP_MTHI) hi <= a;
                        if (op == OP_MTLO) lo <= a;
                        if (is_arith) begin
                            is_div   <= op_div;
                            sgn_a    <= op_signed && a[WIDTH-1];
                            sgn_b    <= op_signed && b[WIDTH-1];
                            div_zero <= op_div && (b == '0);
                            acc      <= {{WIDTH{1'b0}}, op_div ? a_mag : b_mag};
                            opnd     <= op_div ? b_mag : a_mag;
                            cnt      <= '0;
                        end
                    end
                    ST_RUN: begin
                        acc <= chain[UNROLL];
                        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                    end
                    ST_FIX: begin
                        if (is_div) begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                        done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv: UNROLL=1 instance for main tests, UNROLL=4 for the fast path.
module tb_mips_muldiv;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start1, start4, cancel;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy1, done1, busy4, done4;
    logic [31:0] hi1, lo1, hi4, lo4;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mips_muldiv #(.WIDTH(32), .UNROLL(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
    );

    mips_muldiv #(.WIDTH(32), .UNROLL(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
    );

    // Every task is entered and left 1ns after a rising edge.
    task automatic start_op(input bit sel, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y;
        if (sel) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
    endtask

    task automatic wait_done(input bit sel, output int lat);
        int n = 0;
        while (n < 100 && !(sel ? done4 : done1)) begin
            @(posedge clk); #1;
            n++;
        end
        lat = (n < 100) ? n : -1;
    endtask

    task automatic test_reset;
        reset = 1'b0; start1 = 0; start4 = 0; cancel = 0; op = 0; a = 0; b = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy1, done1, busy4, done4} !== 4'b0) begin errors++; $display("FAIL reset_flags busy/done=%b expected 0000", {busy1, done1, busy4, done4}); end
        checks++; if ({hi1, lo1, hi4, lo4} !== 128'b0) begin errors++; $display("FAIL reset_hilo got %h %h %h %h expected zeros", hi1, lo1, hi4, lo4); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult;
        int lat;
        start_op(0, OP_MULT, 32'hFFFFFFFD, 32'd7);
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL mult_busy got %b expected 1", busy1); end
        checks++; if (hi1 !== 32'h0 || lo1 !== 32'h0) begin errors++; $display("FAIL mult_hold got %h %h expected 0 0", hi1, lo1); end
        wait_done(0, lat);
        checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency got %0d expected 33", lat); end
        checks++; if (hi1 !== 32'hFFFFFFFF || lo1 !== 32'hFFFFFFEB || busy1 !== 1'b0) begin errors++; $display("FAIL mult_result got hi=%h lo=%h busy=%b expected FFFFFFFF FFFFFFEB 0", hi1, lo1, busy1); end
        @(posedge clk); #1;
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL done_pulse got %b expected 0", done1); end
        start_op(0, OP_MULTU, 32'hFFFFFFFD, 32'd7);
        wait_done(0, lat);
        checks++; if (hi1 !== 32'h00000006 || lo1 !== 32'hFFFFFFEB) begin errors++; $display("FAIL multu_result got hi=%h lo=%h expected 00000006 FFFFFFEB", hi1, lo1); end
    endtask

    task automatic test_div;
        int lat;
        start_op(0, OP_DIVU, 32'd100, 32'd7);
        wait_done(0, lat);
        checks++; if (lat !== 33 || lo1 !== 32'h0000000E || hi1 !== 32'h00000002) begin errors++; $display("FAIL divu_100_7 got lat=%0d lo=%h hi=%h expected 33 0000000E 00000002", lat, lo1, hi1); end
        start_op(0, OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(0, lat);
        checks++; if (lo1 !== 32'hFFFFFFFD || hi1 !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_m7_2 got lo=%h hi=%h expected FFFFFFFD FFFFFFFF", lo1, hi1); end
        start_op(0, OP_DIV, 32'd7, 32'hFFFFFFFE);
        wait_done(0, lat);
        checks++; if (lo1 !== 32'hFFFFFFFD || hi1 !== 32'h00000001) begin errors++; $display("FAIL div_7_m2 got lo=%h hi=%h expected FFFFFFFD 00000001", lo1, hi1); end
    endtask

    task automatic test_div_edge;
        int lat;
        start_op(0, OP_DIV, 32'd5, 32'd0);
        wait_done(0, lat);
        checks++; if (lat !== 33 || hi1 !== 32'h00000005 || lo1 !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_by_zero got lat=%0d hi=%h lo=%h expected 33 00000005 FFFFFFFF", lat, hi1, lo1); end
        start_op(0, OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(0, lat);
        checks++; if (lo1 !== 32'h80000000 || hi1 !== 32'h00000000) begin errors++; $display("FAIL div_min_m1 got lo=%h hi=%h expected 80000000 00000000", lo1, hi1); end
    endtask

    task automatic test_cancel;
        int seen;
        start_op(0, OP_MTHI, 32'h1234, 32'h0);
        checks++; if (hi1 !== 32'h1234 || busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL mthi got hi=%h busy=%b done=%b expected 1234 0 0", hi1, busy1, done1); end
        start_op(0, OP_MTLO, 32'h5678, 32'h0);
        checks++; if (lo1 !== 32'h5678 || hi1 !== 32'h1234) begin errors++; $display("FAIL mtlo got hi=%h lo=%h expected 1234 5678", hi1, lo1); end
        start_op(0, 3'd6, 32'hDEAD, 32'hBEEF);
        checks++; if (busy1 !== 1'b0 || hi1 !== 32'h1234 || lo1 !== 32'h5678) begin errors++; $display("FAIL reserved_op got busy=%b hi=%h lo=%h expected 0 1234 5678", busy1, hi1, lo1); end
        start_op(0, OP_DIVU, 32'd100, 32'd7);
        repeat (4) begin @(posedge clk); #1; end
        start_op(0, OP_MTHI, 32'hFFFF, 32'h0);
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (busy1 !== 1'b1 || hi1 !== 32'h1234) begin errors++; $display("FAIL start_while_busy got busy=%b hi=%h expected 1 1234", busy1, hi1); end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b expected 0", busy1); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done1) seen++; end
        checks++; if (seen !== 0 || hi1 !== 32'h1234 || lo1 !== 32'h5678) begin errors++; $display("FAIL cancel_result got done_count=%0d hi=%h lo=%h expected 0 1234 5678", seen, hi1, lo1); end
        cancel = 1'b1;
        start_op(0, OP_DIVU, 32'd100, 32'd7);
        cancel = 1'b0;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL cancel_with_start got busy=%b expected 0", busy1); end
        start_op(0, OP_DIVU, 32'd100, 32'd7);
        repeat (32) begin @(posedge clk); #1; end
        checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL fix_state got busy=%b done=%b expected 1 0", busy1, done1); end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        checks++; if (done1 !== 1'b0 || busy1 !== 1'b0 || hi1 !== 32'h1234 || lo1 !== 32'h5678) begin errors++; $display("FAIL cancel_in_fix got done=%b busy=%b hi=%h lo=%h expected 0 0 1234 5678", done1, busy1, hi1, lo1); end
    endtask

    task automatic test_reset_mid;
        int lat;
        start_op(0, OP_MULT, 32'hFFFFFFFD, 32'd7);
        repeat (11) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        checks++; if ({busy1, done1} !== 2'b00 || hi1 !== 32'h0 || lo1 !== 32'h0) begin errors++; $display("FAIL async_reset got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy1, done1, hi1, lo1); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        start_op(0, OP_MULT, 32'd3, 32'd4);
        wait_done(0, lat);
        checks++; if (lat !== 33 || lo1 !== 32'h0000000C || hi1 !== 32'h0) begin errors++; $display("FAIL mult_after_reset got lat=%0d hi=%h lo=%h expected 33 0 0000000C", lat, hi1, lo1); end
    endtask

    task automatic test_back_to_back;
        int lat;
        start_op(1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(1, lat);
        checks++; if (lat !== 9 || hi4 !== 32'hFFFFFFFE || lo4 !== 32'h00000001) begin errors++; $display("FAIL unroll4_multu got lat=%0d hi=%h lo=%h expected 9 FFFFFFFE 00000001", lat, hi4, lo4); end
        start_op(1, OP_DIVU, 32'd100, 32'd7);
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b expected 1", busy4); end
        wait_done(1, lat);
        checks++; if (lat !== 9 || lo4 !== 32'h0000000E || hi4 !== 32'h00000002) begin errors++; $display("FAIL b2b_divu got lat=%0d lo=%h hi=%h expected 9 0000000E 00000002", lat, lo4, hi4); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_edge();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
